// File: rtl/sequence_generator_if.sv
// Handshake and serial-output bundle between a controller and sequence_generator.
// The controller owns the request fields; the generator owns the serial line and status.
interface sequence_generator_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) ();
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             x;
  logic             x_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, gap,
    input  x, x_valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap,
    output x, x_valid, frame_start, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern generator: shifts a captured WIDTH-bit pattern out MSB first,
// repeat_cnt+1 times with gap idle cycles between repetitions.
module sequence_generator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input logic               clk,
  input logic               reset,
  sequence_generator_if.slave bus
);
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LastBit = BW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_rep;
  logic [GAP_W-1:0] r_gap_cfg;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_x;
  logic             r_x_valid;
  logic             r_frame_start;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_pat         <= '0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_rep         <= '0;
      r_gap_cfg     <= '0;
      r_gap_cnt     <= '0;
      r_x           <= 1'b0;
      r_x_valid     <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_pat         <= bus.pattern;
            r_rep         <= bus.repeat_cnt;
            r_gap_cfg     <= bus.gap;
            r_x           <= bus.pattern[WIDTH-1];
            r_shift       <= bus.pattern << 1;
            r_bit_cnt     <= '0;
            r_x_valid     <= 1'b1;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= StSend;
          end
        end
        StSend: begin
          if (r_bit_cnt == LastBit) begin
            if (r_rep != '0) begin
              // Counting down from the captured value means 2^CNT_W-1 never wraps.
              r_rep <= r_rep - 1'b1;
              if (r_gap_cfg != '0) begin
                r_gap_cnt     <= r_gap_cfg;
                r_x           <= 1'b0;
                r_x_valid     <= 1'b0;
                r_frame_start <= 1'b0;
                r_state       <= StGap;
              end else begin
                r_x           <= r_pat[WIDTH-1];
                r_shift       <= r_pat << 1;
                r_bit_cnt     <= '0;
                r_frame_start <= 1'b1;
              end
            end else begin
              r_x           <= 1'b0;
              r_x_valid     <= 1'b0;
              r_frame_start <= 1'b0;
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
              r_state       <= StDone;
            end
          end else begin
            r_x           <= r_shift[WIDTH-1];
            r_shift       <= r_shift << 1;
            r_bit_cnt     <= r_bit_cnt + 1'b1;
            r_frame_start <= 1'b0;
          end
        end
        StGap: begin
          if (r_gap_cnt == GAP_W'(1)) begin
            r_x           <= r_pat[WIDTH-1];
            r_shift       <= r_pat << 1;
            r_bit_cnt     <= '0;
            r_x_valid     <= 1'b1;
            r_frame_start <= 1'b1;
            r_state       <= StSend;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.x           = r_x;
  assign bus.x_valid     = r_x_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: expected per-cycle output vectors are queued
// when a frame is requested and compared cycle by cycle as the DUT emits them.
module tb_sequence_generator;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP_W = 4;

  typedef struct packed {
    logic x;
    logic x_valid;
    logic frame_start;
    logic busy;
    logic done;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sequence_generator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  sequence_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic obs_t observe();
    obs_t o;
    o.x           = bus.x;
    o.x_valid     = bus.x_valid;
    o.frame_start = bus.frame_start;
    o.busy        = bus.busy;
    o.done        = bus.done;
    return o;
  endfunction

  // Expected cycle-by-cycle outputs following the accepting edge.
  task automatic push_frame(input logic [WIDTH-1:0] pat, input int rep, input int gp);
    obs_t e;
    for (int r = 0; r <= rep; r++) begin
      for (int k = 0; k < WIDTH; k++) begin
        e.x           = pat[WIDTH-1-k];
        e.x_valid     = 1'b1;
        e.frame_start = (k == 0);
        e.busy        = 1'b1;
        e.done        = 1'b0;
        exp_q.push_back(e);
      end
      if (r < rep) begin
        for (int g = 0; g < gp; g++) begin
          e = '{x: 1'b0, x_valid: 1'b0, frame_start: 1'b0, busy: 1'b1, done: 1'b0};
          exp_q.push_back(e);
        end
      end
    end
    e = '{x: 1'b0, x_valid: 1'b0, frame_start: 1'b0, busy: 1'b0, done: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic request(input logic [WIDTH-1:0] pat, input int rep, input int gp);
    bus.start      = 1'b1;
    bus.pattern    = pat;
    bus.repeat_cnt = CNT_W'(rep);
    bus.gap        = GAP_W'(gp);
  endtask

  task automatic test_reset();
    obs_t got;
    reset = 1'b1;
    bus.start = 1'b0; bus.pattern = '0; bus.repeat_cnt = '0; bus.gap = '0;
    #2;
    got = observe();
    n_vec++;
    if (got !== obs_t'(0)) begin
      n_err++; $display("FAIL reset_hold: got %b want %b", got, obs_t'(0));
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    got = observe();
    n_vec++;
    if (got !== obs_t'(0)) begin
      n_err++; $display("FAIL reset_idle: got %b want %b", got, obs_t'(0));
    end
  endtask

  task automatic test_frame(input string name, input logic [WIDTH-1:0] pat,
                            input int rep, input int gp);
    obs_t got, e;
    int   cyc = 0;
    @(negedge clk);
    push_frame(pat, rep, gp);
    request(pat, rep, gp);
    @(negedge clk);
    bus.start = 1'b0;
    while (exp_q.size() > 0) begin
      got = observe();
      e   = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL %s cycle %0d: got %b want %b", name, cyc + 1, got, e);
      end
      cyc++;
      @(negedge clk);
    end
    got = observe();
    n_vec++;
    if (got !== obs_t'(0)) begin
      n_err++; $display("FAIL %s idle_after: got %b want %b", name, got, obs_t'(0));
    end
  endtask

  // Mid-frame start pulse and input changes must not disturb the frame in flight.
  task automatic test_ignore_start();
    obs_t got, e;
    int   cyc = 0;
    @(negedge clk);
    push_frame(4'b1110, 1, 1);
    request(4'b1110, 1, 1);
    @(negedge clk);
    bus.start = 1'b0;
    while (exp_q.size() > 0) begin
      if (cyc == 1) request(4'b0000, 15, 15);
      if (cyc == 2) bus.start = 1'b0;
      got = observe();
      e   = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL ignore_start cycle %0d: got %b want %b", cyc + 1, got, e);
      end
      cyc++;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      got = observe();
      n_vec++;
      if (got !== obs_t'(0)) begin
        n_err++; $display("FAIL ignore_start no_second_frame %0d: got %b want %b",
                          i, got, obs_t'(0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, e;
    @(negedge clk);
    push_frame(4'b1011, 3, 2);
    request(4'b1011, 3, 2);
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      got = observe();
      e   = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL reset_mid pre cycle %0d: got %b want %b", cyc + 1, got, e);
      end
      if (cyc < 2) @(negedge clk);
    end
    exp_q.delete();
    #1 reset = 1'b1;
    #1;
    got = observe();
    n_vec++;
    if (got !== obs_t'(0)) begin
      n_err++; $display("FAIL reset_mid async_clear: got %b want %b", got, obs_t'(0));
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = observe();
      n_vec++;
      if (got !== obs_t'(0)) begin
        n_err++; $display("FAIL reset_mid post_idle %0d: got %b want %b", i, got, obs_t'(0));
      end
    end
    test_frame("reset_mid_fresh", 4'b0110, 1, 0);
  endtask

  // start held high: one idle cycle after DONE, then the next frame.
  task automatic test_back_to_back();
    obs_t got, e;
    int   cyc = 0;
    int   len1;
    @(negedge clk);
    push_frame(4'b1100, 0, 0);
    len1 = exp_q.size();
    exp_q.push_back(obs_t'(0));
    push_frame(4'b1100, 0, 0);
    request(4'b1100, 0, 0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      if (cyc == len1 + 1) bus.start = 1'b0;
      got = observe();
      e   = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL back_to_back cycle %0d: got %b want %b", cyc + 1, got, e);
      end
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  // Bench-side pattern detector on the serial line; it must fire once per repetition.
  task automatic test_loopback();
    obs_t             got, e;
    logic [WIDTH-1:0] target = 4'b1101;
    logic [WIDTH-1:0] hist   = '0;
    int               hcnt   = 0;
    int               hits   = 0;
    int               gap_hits = 0;
    int               cyc    = 0;
    @(negedge clk);
    push_frame(target, 2, 1);
    request(target, 2, 1);
    @(negedge clk);
    bus.start = 1'b0;
    while (exp_q.size() > 0) begin
      got = observe();
      e   = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL loopback cycle %0d: got %b want %b", cyc + 1, got, e);
      end
      if (got.x_valid) begin
        hist = {hist[WIDTH-2:0], got.x};
        hcnt++;
        if (hcnt >= WIDTH && hist == target) hits++;
      end else begin
        if (got.busy && hcnt >= WIDTH && hist == target && hcnt == 0) gap_hits++;
        hist = '0;
        hcnt = 0;
      end
      cyc++;
      @(negedge clk);
    end
    n_vec++;
    if (hits != 3 || gap_hits != 0) begin
      n_err++; $display("FAIL loopback detections: got %0d (gap %0d) want 3 (gap 0)",
                        hits, gap_hits);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] pat;
    int rep, gp;
    for (int i = 0; i < 6; i++) begin
      pat = WIDTH'($urandom);
      rep = int'($urandom_range(0, 3));
      gp  = int'($urandom_range(0, 3));
      test_frame("random", pat, rep, gp);
    end
  endtask

  initial begin
    test_reset();
    test_frame("single_1101", 4'b1101, 0, 0);
    test_frame("repeat_nogap_1011", 4'b1011, 1, 0);
    test_frame("repeat_gap2_1001", 4'b1001, 1, 2);
    test_ignore_start();
    test_reset_mid();
    test_loopback();
    test_back_to_back();
    test_frame("max_repeat", 4'b1010, 15, 0);
    test_frame("max_gap", 4'b0111, 1, 15);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
